// File: rtl/irq_pending_latch.sv
// -----------------------------------------------------------------------------
// irq_pending_latch
//   Front end of the 8x3 priority encoder. Each raw interrupt line is passed
//   through a SYNC_STAGES-deep synchroniser. A synchronised rising edge sets a
//   sticky pending bit. The masked pending vector drives the encoder input.
//   A three-state FSM (IDLE / ASSERT / SERVICE) runs the irq / ack / eoi
//   handshake with the CPU. The encoder's code returns as ack_idx and clears
//   the pending bit that won.
//
//   Build option: define IRQ_LEVEL_EN for level mode. In level mode each
//   pending bit follows the synchronised line level, and ack clears nothing.
//   If IRQ_LEVEL_EN is not defined, pending bits are edge-latched and sticky.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   irq_in   in   N   raw asynchronous interrupt lines
//   mask     in   N   per-line enable (1 = enabled); masked lines still latch
//   pend     out  N   pending & mask, drives encoder 'in'
//   irq      out  1   interrupt request to CPU (high in ASSERT)
//   ack      in   1   CPU accept pulse
//   ack_idx  in   IW  encoder code sampled with ack
//   eoi      in   1   end-of-interrupt pulse
//   isr_idx  out  IW  index currently in service (holds outside SERVICE)
//   busy     out  1   high in SERVICE
// -----------------------------------------------------------------------------
module irq_pending_latch #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int IW          = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  irq_in,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  pend,
    output logic          irq,
    input  logic          ack,
    input  logic [IW-1:0] ack_idx,
    input  logic          eoi,
    output logic [IW-1:0] isr_idx,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  line_s;
    logic [N-1:0]                  pend_q, pend_d;
    logic [IW-1:0]                 isr_idx_q, isr_idx_d;
    logic                          ack_ok;

    // Synchroniser chain: stage 0 samples the raw lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign line_s = sync_q[SYNC_STAGES-1];
    assign pend   = pend_q & mask;

    // An ack counts only in ASSERT, only with an in-range index, and only when
    // that line is currently presented (pending and unmasked).
    always_comb begin
        ack_ok = 1'b0;
        if (state_q == S_ASSERT && ack && (int'(ack_idx) < N)) begin
            ack_ok = pend[ack_idx];
        end
    end

`ifdef IRQ_LEVEL_EN
    always_comb begin
        pend_d = line_s;
    end
`else
    logic [N-1:0] prev_q;
    logic [N-1:0] rise;
    logic [N-1:0] clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= line_s;
        end
    end

    assign rise = line_s & ~prev_q;

    // The clear is applied before the OR. A rise in the same cycle as an ack
    // of that bit therefore wins, and the new edge is kept.
    always_comb begin
        clr = '0;
        if (ack_ok) begin
            clr[ack_idx] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | rise;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            state_q   <= S_IDLE;
            isr_idx_q <= '0;
        end else begin
            pend_q    <= pend_d;
            state_q   <= state_d;
            isr_idx_q <= isr_idx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        isr_idx_d = isr_idx_q;
        case (state_q)
            S_IDLE: begin
                if (|pend) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                // If ack and eoi arrive together, only ack is acted on.
                if (ack_ok) begin
                    state_d   = S_SERVICE;
                    isr_idx_d = ack_idx;
                end else if (!(|pend)) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (eoi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        irq     = (state_q == S_ASSERT);
        busy    = (state_q == S_SERVICE);
        isr_idx = isr_idx_q;
    end

endmodule
